// File: rtl/glyph_pkg.sv
// Shared types and constants for the score glyph renderer.
// Contents: glyph geometry, transparent key colour, conversion FSM states,
//           BCD digit type and the score clamp helper.
package glyph_pkg;

  localparam int          GLYPH_W   = 32;
  localparam int          GLYPH_H   = 32;
  localparam logic [23:0] KEY_COLOR = 24'hFFFFFF;
  localparam logic [19:0] SCORE_MAX = 20'd999999;
  // One double-dabble iteration per input bit.
  localparam int          DD_ITERS  = 20;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } conv_state_t;

  typedef logic [3:0] bcd_t;

  function automatic logic [19:0] clamp_score(input logic [19:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one iteration per clock.
// Ports: i_start loads i_bin and clears the digits; o_done is high during the
//        final iteration cycle; o_bcd holds the digits (index 0 = least significant).
module bin2bcd_seq
  import glyph_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [19:0]                  i_bin,
  output logic                         o_done,
  output bcd_t [NUM_DIGITS-1:0]        o_bcd
);

  localparam int BW = NUM_DIGITS * 4;

  logic [19:0]   r_bin;
  logic [BW-1:0] r_bcd;
  logic [4:0]    r_cnt;
  logic          r_run;
  logic [BW-1:0] w_adj;

  // Add-3 correction on every digit >= 5 before each shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] > 4'd4) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign o_done = r_run && (r_cnt == 5'(DD_ITERS - 1));
  assign o_bcd  = r_bcd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt + 5'd1;
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/score_glyph_ctrl.sv
// Score overlay: converts a binary score to BCD and renders it as glyphs.
// Ports: score_in/score_load/frame_start control conversion and commit;
//        DrawX/DrawY -> rom_addr/glyph_sel (+1 cycle) -> rom_data -> pixel_on/pixel_rgb (+3 cycles).
module score_glyph_ctrl
  import glyph_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ORIGIN_X   = 10,
  parameter int ORIGIN_Y   = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] score_in,
  input  logic        score_load,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [23:0] rom_data,
  output logic [3:0]  glyph_sel,
  output logic [9:0]  rom_addr,
  output logic        busy,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb
);

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_W);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GLYPH_H);

  conv_state_t           r_state;
  logic                  r_busy;
  logic                  r_pend_vld;
  logic [19:0]           r_pend_val;
  bcd_t [NUM_DIGITS-1:0] r_disp;

  logic                  w_start;
  logic                  w_done;
  logic [19:0]           w_operand;
  bcd_t [NUM_DIGITS-1:0] w_work;

  // A fresh load in IDLE supersedes anything pending.
  assign w_start   = (r_state == IDLE) && (score_load || r_pend_vld);
  assign w_operand = clamp_score(score_load ? score_in : r_pend_val);

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_start (w_start),
    .i_bin   (w_operand),
    .o_done  (w_done),
    .o_bcd   (w_work)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= SHIFT;
            r_busy     <= 1'b1;
            r_pend_vld <= 1'b0;
          end
        end
        SHIFT: begin
          if (score_load) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= score_in;
          end
          if (w_done) begin
            r_state <= HOLD;
            r_busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (score_load) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= score_in;
          end
          // Digits only reach the screen at vertical blank to avoid tearing.
          if (frame_start) begin
            r_disp  <= w_work;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;

  // ---------------- pixel pipeline ----------------
  logic [9:0] w_dx;
  logic [4:0] w_row;
  logic [4:0] w_slot;
  logic       w_in_box;
  bcd_t       w_digit;
  logic       w_blank;
  logic       w_lead;
  logic       w_pix_on;

  logic        r_in_box1, r_blank1, r_in_box2, r_blank2;
  logic [3:0]  r_glyph_sel;
  logic [9:0]  r_rom_addr;
  logic        r_pixel_on;
  logic [23:0] r_pixel_rgb;

  assign w_dx     = DrawX - X_LO[9:0];
  assign w_row    = DrawY[4:0] - Y_LO[4:0];
  assign w_slot   = w_dx[9:5];
  assign w_in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                    ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

  // Slot 0 is the most significant digit. w_lead stays high while every slot
  // from the left up to the current one is zero; the last slot always shows.
  always_comb begin
    w_digit = '0;
    w_blank = 1'b0;
    w_lead  = 1'b1;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      w_lead = w_lead && (r_disp[NUM_DIGITS-1-s] == 4'd0);
      if (w_slot == 5'(s)) begin
        w_digit = r_disp[NUM_DIGITS-1-s];
        w_blank = w_lead && (s != NUM_DIGITS - 1);
      end
    end
  end

  assign w_pix_on = r_in_box2 && !r_blank2 && (rom_data != KEY_COLOR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_in_box1   <= 1'b0;
      r_blank1    <= 1'b0;
      r_in_box2   <= 1'b0;
      r_blank2    <= 1'b0;
      r_glyph_sel <= '0;
      r_rom_addr  <= '0;
      r_pixel_on  <= 1'b0;
      r_pixel_rgb <= '0;
    end else begin
      r_in_box1   <= w_in_box;
      r_blank1    <= w_in_box && w_blank;
      r_glyph_sel <= w_in_box ? w_digit : 4'd0;
      r_rom_addr  <= w_in_box ? {w_row, w_dx[4:0]} : 10'd0;
      // Stage 2 lines up with the ROM read latency.
      r_in_box2   <= r_in_box1;
      r_blank2    <= r_blank1;
      r_pixel_on  <= w_pix_on;
      r_pixel_rgb <= w_pix_on ? rom_data : 24'h000000;
    end
  end

  assign glyph_sel = r_glyph_sel;
  assign rom_addr  = r_rom_addr;
  assign pixel_on  = r_pixel_on;
  assign pixel_rgb = r_pixel_rgb;

endmodule

// File: tb/tb_score_glyph_ctrl.sv
// Bench for score_glyph_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural score/pixel model.
module tb_score_glyph_ctrl;

  localparam int ND = 6;
  localparam int OX = 10;
  localparam int OY = 10;

  logic        Clk = 1'b0;
  logic        Reset, score_load, frame_start;
  logic [19:0] score_in;
  logic [9:0]  DrawX, DrawY;
  logic [23:0] rom_data;
  logic [3:0]  glyph_sel;
  logic [9:0]  rom_addr;
  logic        busy, pixel_on;
  logic [23:0] pixel_rgb;

  score_glyph_ctrl #(.NUM_DIGITS(ND), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
    .Clk(Clk), .Reset(Reset), .score_in(score_in), .score_load(score_load),
    .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY), .rom_data(rom_data),
    .glyph_sel(glyph_sel), .rom_addr(rom_addr), .busy(busy),
    .pixel_on(pixel_on), .pixel_rgb(pixel_rgb)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_disp, m_held, m_pend_val, conv_left;
  bit  m_started, held_valid, pend_valid;
  bit  ib_d1, ib_d2, bl_d1, bl_d2;
  logic        e_busy, e_pon;
  logic [3:0]  e_glyph;
  logic [9:0]  e_addr;
  logic [23:0] e_rgb;

  function automatic int digit_at(input int v, input int slot);
    int p = 1;
    for (int i = 0; i < ND - 1 - slot; i++) p *= 10;
    return (v / p) % 10;
  endfunction

  function automatic bit slot_shown(input int v, input int slot);
    int nd = 1;
    int t  = v;
    while (t >= 10) begin
      t /= 10;
      nd++;
    end
    return slot >= ND - nd;
  endfunction

  function automatic int clamp(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  always @(posedge Clk) begin : model
    int dx, dy, slot;
    bit ib, on;
    if (Reset) begin
      m_started = 1; m_disp = 0; conv_left = 0; held_valid = 0; pend_valid = 0;
      ib_d1 = 0; ib_d2 = 0; bl_d1 = 0; bl_d2 = 0;
      e_busy = 0; e_pon = 0; e_rgb = 0; e_glyph = 0; e_addr = 0;
    end else begin
      on    = ib_d2 && !bl_d2 && (rom_data != 24'hFFFFFF);
      e_pon = on;
      e_rgb = on ? rom_data : 24'h0;
      ib_d2 = ib_d1; bl_d2 = bl_d1;
      dx = int'(DrawX) - OX;
      dy = int'(DrawY) - OY;
      ib = (dx >= 0) && (dx < ND * 32) && (dy >= 0) && (dy < 32);
      if (ib) begin
        slot    = dx / 32;
        e_glyph = 4'(digit_at(m_disp, slot));
        e_addr  = 10'((dy % 32) * 32 + (dx % 32));
        bl_d1   = !slot_shown(m_disp, slot);
      end else begin
        e_glyph = 0; e_addr = 0; bl_d1 = 0;
      end
      ib_d1 = ib;
      if (conv_left > 0) begin
        if (score_load) begin pend_valid = 1; m_pend_val = int'(score_in); end
        conv_left--;
        if (conv_left == 0) held_valid = 1;
      end else if (held_valid) begin
        if (score_load) begin pend_valid = 1; m_pend_val = int'(score_in); end
        if (frame_start) begin m_disp = m_held; held_valid = 0; end
      end else if (score_load) begin
        conv_left = 20; m_held = clamp(int'(score_in)); pend_valid = 0;
      end else if (pend_valid) begin
        conv_left = 20; m_held = clamp(m_pend_val); pend_valid = 0;
      end
      e_busy = (conv_left > 0);
    end
  end

  always @(posedge Clk) begin : compare
    #1;
    if (m_started) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("glyph_sel", 32'(glyph_sel), 32'(e_glyph));
      check("rom_addr", 32'(rom_addr), 32'(e_addr));
      check("pixel_on", 32'(pixel_on), 32'(e_pon));
      check("pixel_rgb", 32'(pixel_rgb), 32'(e_rgb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge Clk);
    score_load = 0; frame_start = 0; Reset = 0;
  endtask

  task automatic load(input logic [19:0] v);
    score_in = v; score_load = 1; cyc();
  endtask

  task automatic frame();
    frame_start = 1; cyc();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; cyc(); end
  endtask

  task automatic probe(input int x, input int y, output logic [3:0] g, output logic [9:0] a);
    DrawX = 10'(x); DrawY = 10'(y); cyc();
    g = glyph_sel; a = rom_addr;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] c,
                     output logic on, output logic [23:0] rgb);
    DrawX = 10'(x); DrawY = 10'(y);
    cyc(); cyc();
    rom_data = c; cyc();
    on = pixel_on; rgb = pixel_rgb;
    rom_data = 24'h00FF00;
  endtask

  function automatic int cx(input int slot);
    return OX + slot * 32 + 16;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  g;
    logic [9:0]  a;
    logic        on;
    logic [23:0] rgb;
    int          n;
    Reset = 1; score_in = 0; score_load = 0; frame_start = 0;
    DrawX = 0; DrawY = 0; rom_data = 24'h00FF00;
    cyc();
    check("reset_busy", 32'(busy), 0);
    check("reset_pixel_on", 32'(pixel_on), 0);
    check("reset_rgb", 32'(pixel_rgb), 0);
    check("reset_glyph", 32'(glyph_sel), 0);
    check("reset_addr", 32'(rom_addr), 0);

    // 123456: busy width, digit order, address formation, key colour
    load(20'd123456);
    check("busy_rise", 32'(busy), 1);
    wait_idle(n);
    check("busy_cycles", 32'(n), 20);
    frame();
    for (int s = 0; s < ND; s++) begin
      probe(cx(s), OY + 16, g, a);
      check("glyph_123456", 32'(g), 32'(s + 1));
    end
    probe(OX + 33, OY + 2, g, a);
    check("addr_041", 32'(a), 32'h041);
    check("addr_glyph", 32'(g), 2);
    pix(OX + 33, OY + 2, 24'hFFFFFF, on, rgb);
    check("white_off", 32'(on), 0);
    check("white_rgb", 32'(rgb), 0);
    pix(OX + 33, OY + 2, 24'hABCDEF, on, rgb);
    check("colour_on", 32'(on), 1);
    check("colour_rgb", 32'(rgb), 32'hABCDEF);
    pix(OX - 1, OY + 2, 24'hABCDEF, on, rgb);
    check("left_edge_off", 32'(on), 0);
    pix(OX + ND * 32, OY + 2, 24'hABCDEF, on, rgb);
    check("right_edge_off", 32'(on), 0);
    probe(OX + ND * 32 - 1, OY + 31, g, a);
    check("corner_addr", 32'(a), 32'h3FF);

    // 42: leading-zero blanking
    load(20'd42); wait_idle(n); frame();
    for (int s = 0; s < 4; s++) begin
      pix(cx(s), OY + 5, 24'h00FF00, on, rgb);
      check("blank_42", 32'(on), 0);
    end
    probe(cx(4), OY + 5, g, a); check("glyph_42_s4", 32'(g), 4);
    probe(cx(5), OY + 5, g, a); check("glyph_42_s5", 32'(g), 2);
    pix(cx(4), OY + 5, 24'h00FF00, on, rgb); check("show_42_s4", 32'(on), 1);

    // 0: only the rightmost slot shows
    load(20'd0); wait_idle(n); frame();
    probe(cx(5), OY + 5, g, a); check("glyph_0", 32'(g), 0);
    pix(cx(5), OY + 5, 24'h00FF00, on, rgb); check("show_0_s5", 32'(on), 1);
    pix(cx(4), OY + 5, 24'h00FF00, on, rgb); check("blank_0_s4", 32'(on), 0);

    // clamp
    load(20'd1048575); wait_idle(n); frame();
    for (int s = 0; s < ND; s++) begin
      probe(cx(s), OY + 5, g, a);
      check("clamp_9", 32'(g), 9);
    end

    // pending load during SHIFT
    load(20'd7); cyc(); cyc(); cyc();
    load(20'd9); wait_idle(n); frame();
    probe(cx(5), OY + 5, g, a); check("pend_first", 32'(g), 7);
    check("pend_autostart", 32'(busy), 1);
    wait_idle(n);
    probe(cx(5), OY + 5, g, a); check("pend_held", 32'(g), 7);
    frame();
    probe(cx(5), OY + 5, g, a); check("pend_second", 32'(g), 9);

    // reset in the middle of SHIFT
    load(20'd555555);
    repeat (9) cyc();
    Reset = 1; cyc();
    check("abort_busy", 32'(busy), 0);
    frame();
    probe(cx(5), OY + 5, g, a); check("abort_glyph", 32'(g), 0);
    pix(cx(5), OY + 5, 24'h00FF00, on, rgb); check("abort_show", 32'(on), 1);
    pix(cx(0), OY + 5, 24'h00FF00, on, rgb); check("abort_blank", 32'(on), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 599) == 0);
      score_load  = ($urandom_range(0, 29) == 0);
      frame_start = ($urandom_range(0, 24) == 0);
      score_in    = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'hFFFFF))
                                                : 20'($urandom_range(0, 2000));
      DrawX       = 10'($urandom_range(0, OX + ND * 32 + 20));
      DrawY       = 10'($urandom_range(0, OY + 50));
      rom_data    = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
